// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch, decode, operand fetch, execute, store, retire over a req/done bus.
// Reg-reg op takes 7 cycles FETCH-to-done (imm/NOT 6, BZ/HALT 3); each bus state holds its request until done.
module cpu_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OPR_AW = 8,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET = '0,
  parameter int PC_STEP = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  run_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  halted,
  output logic                  err,
  output logic [31:0]           instr_count,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero_flag,
  output logic                  read_req,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_done,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_err,
  output logic                  write_req,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_done,
  input  logic                  write_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OP1, S_OP2, S_EXEC, S_STORE, S_RETIRE, S_ERROR
  } state_t;

  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_BZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instr, operand1, operand2, result;
  logic [3:0]            opcode;
  logic                  imm, zero_q, run_q, halted_q, err_q;
  logic [OPR_AW-1:0]     src1, src2, dst;
  logic [31:0]           count;
  logic [3:0]            instr_op;
  logic                  retire_stop;

  assign instr_op    = instr[DATA_WIDTH-1 -: 4];
  assign retire_stop = (opcode == OP_HALT) || !run_q;

  // Bits between the imm flag and src1 carry no meaning.
  if (DATA_WIDTH > 5 + 3*OPR_AW) begin : g_spare
    logic spare_unused;
    assign spare_unused = ^instr[DATA_WIDTH-6:3*OPR_AW];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (read_done) state_next = read_err ? S_ERROR : S_DECODE;
      S_DECODE: state_next = (instr_op == OP_HALT || instr_op == OP_BZ) ? S_RETIRE : S_OP1;
      S_OP1: begin
        if (read_done) begin
          if (read_err)                        state_next = S_ERROR;
          else if (opcode == OP_NOT || imm)    state_next = S_EXEC;
          else                                 state_next = S_OP2;
        end
      end
      S_OP2:    if (read_done) state_next = read_err ? S_ERROR : S_EXEC;
      S_EXEC:   state_next = S_STORE;
      S_STORE:  if (write_done) state_next = write_err ? S_ERROR : S_RETIRE;
      S_RETIRE: state_next = retire_stop ? S_IDLE : S_FETCH;
      S_ERROR:  if (start) state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE) && (state != S_ERROR);
    done       = (state == S_RETIRE) && retire_stop;
    read_req   = 1'b0;
    read_addr  = '0;
    write_req  = 1'b0;
    write_addr = '0;
    write_data = '0;
    case (state)
      S_FETCH: begin
        read_req  = 1'b1;
        read_addr = pc;
      end
      S_OP1: begin
        read_req  = 1'b1;
        read_addr = ADDR_WIDTH'(src1);
      end
      S_OP2: begin
        read_req  = 1'b1;
        read_addr = ADDR_WIDTH'(src2);
      end
      S_STORE: begin
        write_req  = 1'b1;
        write_addr = ADDR_WIDTH'(dst);
        write_data = result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pc       <= PC_RESET;
      instr    <= '0;
      opcode   <= '0;
      imm      <= 1'b0;
      src1     <= '0;
      src2     <= '0;
      dst      <= '0;
      operand1 <= '0;
      operand2 <= '0;
      result   <= '0;
      zero_q   <= 1'b0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            run_q    <= run_mode;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (read_done && read_err)  err_q <= 1'b1;
          if (read_done && !read_err) instr <= read_data;
        end
        S_DECODE: begin
          opcode <= instr_op;
          imm    <= instr[DATA_WIDTH-5];
          src1   <= instr[3*OPR_AW-1 -: OPR_AW];
          src2   <= instr[2*OPR_AW-1 -: OPR_AW];
          dst    <= instr[OPR_AW-1:0];
        end
        S_OP1: begin
          if (read_done && read_err) err_q <= 1'b1;
          if (read_done && !read_err) begin
            operand1 <= read_data;
            if (imm && opcode != OP_NOT) operand2 <= DATA_WIDTH'(src2);
          end
        end
        S_OP2: begin
          if (read_done && read_err)  err_q    <= 1'b1;
          if (read_done && !read_err) operand2 <= read_data;
        end
        S_EXEC: begin
          result <= alu_result;
          zero_q <= alu_zero_flag;
        end
        S_STORE: begin
          if (write_done && write_err) err_q <= 1'b1;
        end
        S_RETIRE: begin
          if (opcode == OP_BZ && zero_q) pc <= ADDR_WIDTH'(dst);
          else                           pc <= pc + ADDR_WIDTH'(PC_STEP);
          count <= count + 32'd1;
          if (opcode == OP_HALT) halted_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_opcode    = opcode;
  assign alu_operand_a = operand1;
  assign alu_operand_b = operand2;
  assign halted        = halted_q;
  assign err           = err_q;
  assign instr_count   = count;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Second-generation instruction sequencer for the ALU core. It fetches 32-bit-style instructions over the AXI master request/done interface, decodes them, fetches operands, drives the ALU and writes results back. Compared with the single-shot controller it adds:
- parametrised operand-address width and PC step
- continuous run mode
- immediate operands, BZ branch and HALT
- bus-error trapping
- a retired-instruction counter

It sits between the system start/status logic and the ALU plus the AXI read/write master front-end.

Parameters:
ADDR_WIDTH, 32, width of read_addr/write_addr/pc.
DATA_WIDTH, 32, instruction/operand/result width; must be >= 5+3*OPR_AW.
OPR_AW, 8, width of each src1/src2/dst address field.
PC_RESET, 0, PC value after reset.
PC_STEP, 4, PC increment per non-taken instruction.

Ports:
ACLK  in  1  clock
ARESET  in  1  reset, asynchronous, active-high
start  in  1  begin execution from IDLE
run_mode  in  1  0 = single-step, 1 = run until HALT; sampled in IDLE when start=1
busy  out  1  high in every state except IDLE and ERROR
done  out  1  one-cycle retirement pulse (see Behaviour)
halted  out  1  set on HALT retirement; cleared by start
err  out  1  sticky bus-error flag; cleared by start
instr_count  out  32  retired-instruction count, wraps at 2^32
alu_opcode  out  4  opcode to ALU
alu_operand_a  out  DATA_WIDTH  operand1 register
alu_operand_b  out  DATA_WIDTH  operand2 register
alu_result  in  DATA_WIDTH  ALU result
alu_zero_flag  in  1  ALU zero flag
read_req  out  1  read request
read_addr  out  ADDR_WIDTH  read address
read_done  in  1  read complete; read_data valid this cycle
read_data  in  DATA_WIDTH  read data
read_err  in  1  qualifies read_done: error response
write_req  out  1  write request
write_addr  out  ADDR_WIDTH  write address
write_data  out  DATA_WIDTH  write data
write_done  in  1  write complete
write_err  in  1  qualifies write_done: error response

Behaviour:

Reset (ARESET=1, asynchronous, any state including mid-transaction):
- state=IDLE, pc=PC_RESET.
- All internal registers cleared; instr_count=0, halted=0, err=0, zero_q=0.
- read_req/write_req drop immediately.
- Any in-flight done/err response after reset is ignored.

Outputs:
- Combinational from state/registers, no latches.
- read_addr, write_addr and write_data are 0 whenever their req is low.
- alu_opcode/alu_operand_a/alu_operand_b always reflect the opcode/operand1/operand2 registers.

Instruction format:
- opcode = instr[DW-1:DW-4]
- imm = instr[DW-5]
- src1 = instr[3*OPR_AW-1:2*OPR_AW]
- src2 = instr[2*OPR_AW-1:OPR_AW]
- dst = instr[OPR_AW-1:0]
- Address fields are zero-extended byte addresses.

Opcodes:
- 0x0-0xD: ALU ops.
- 0x5 (NOT): single operand.
- 0xE: BZ.
- 0xF: HALT.

State machine:
- IDLE:
  - start=1 → FETCH; latches run_mode, clears halted/err.
  - start while busy is ignored.
- FETCH:
  - read_req=1, read_addr=pc.
  - On read_done: latch instruction → DECODE.
- DECODE:
  - Latch fields (one cycle).
  - HALT → RETIRE.
  - BZ → RETIRE.
  - Otherwise → OP1.
- OP1:
  - read src1.
  - On done: operand1=read_data.
  - Then NOT → EXEC; imm=1 → EXEC with operand2 = zero-extended src2 field; else → OP2.
- OP2:
  - read src2.
  - On done: operand2=read_data → EXEC.
- EXEC:
  - One cycle; result=alu_result, zero_q=alu_zero_flag → STORE.
- STORE:
  - write_req=1, write_addr=dst, write_data=result.
  - On write_done → RETIRE.
- RETIRE (one cycle):
  - PC update:
    - BZ with zero_q=1: pc = zero-extended dst.
    - Otherwise: pc = pc+PC_STEP, wrapping mod 2^ADDR_WIDTH.
  - instr_count+1.
  - HALT: halted=1, done=1 → IDLE; pc points past HALT.
  - Single-step: done=1 → IDLE.
  - Run mode, non-HALT: no done → FETCH.
- Bus errors:
  - A done with err=1 in any read/write state → ERROR.
  - On entering ERROR: err=1; no register, PC or count update.
- ERROR:
  - busy=0.
  - start=1 → FETCH, re-executing the same pc, err cleared.

Request handshake:
- Requests are held with a stable address until done.
- The done input is ignored outside the matching state.

Latency:
- Minimum reg-reg ALU instruction, done returned in the request cycle: FETCH, DECODE, OP1, OP2, EXEC, STORE, RETIRE = 7 cycles from FETCH entry to done.
- Immediate or NOT form: 6 cycles.
- BZ/HALT: 3 cycles.

Test Plan:
- Single-step ADD (0x0): instr 0x00101418, mem[0x10]=5, mem[0x14]=7, zero-wait done → write 12 to 0x18; done pulse at cycle 7; pc=4; instr_count=1; busy low afterwards.
- Immediate + NOT: instr with imm=1, src2=0x22 → operand2=0x22, OP2 skipped. NOT (0x5) → only one read, result=~mem[src1], written to dst.
- Run mode program: ADD, then SUB giving 0, then BZ dst=0x40, with HALT at 0x40 → pc jumps to 0x40; single done at HALT; halted=1; instr_count=4; final pc=0x44.
- BZ not taken: preceding result nonzero → pc+=4, no write transaction.
- Bus error: read_err on OP2 → err=1, busy=0, no write, pc/count unchanged; next start re-fetches same pc and completes.
- Async reset asserted mid-STORE with write_req high → write_req low the same cycle; all outputs at reset values; later write_done is ignored.
